// File: rtl/carrier_generator.sv
// carrier_generator: prescaled up / down / up-down PWM carrier with
// one-clock min/max event pulses and a double-buffered period.
//
// The shadow period (period_active) is reloaded from period_in only when
// the carrier produces 0 (up, up-down) or when it wraps 0 -> top (down).
// A running cycle is therefore never truncated by a software write.
//
// Events are computed from the value the carrier is about to take and
// registered alongside it. min_evt and max_evt therefore line up with the
// clock on which carrier_out first shows the endpoint value.
module carrier_generator #(
  parameter int CARR_WIDTH  = 16,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   carr_onoff,
  input  logic [1:0]             carr_mode,
  input  logic [1:0]             count_mode,
  input  logic [CARR_WIDTH-1:0]  period_in,
  input  logic [CARR_WIDTH-1:0]  init_in,
  input  logic [PRESC_WIDTH-1:0] prescaler_in,
  output logic [CARR_WIDTH-1:0]  carrier_out,
  output logic                   dir_out,
  output logic                   min_evt,
  output logic                   max_evt,
  output logic                   carr_event,
  output logic [CARR_WIDTH-1:0]  period_active
);

  localparam logic [1:0] MODE_UP     = 2'd0;
  localparam logic [1:0] MODE_DOWN   = 2'd1;
  localparam logic [1:0] MODE_UPDOWN = 2'd2;

  localparam logic [1:0] CNT_MIN     = 2'd1;
  localparam logic [1:0] CNT_MAX     = 2'd2;
  localparam logic [1:0] CNT_MINMAX  = 2'd3;

  localparam logic [CARR_WIDTH-1:0]  C_ONE = {{(CARR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRESC_WIDTH-1:0] P_ONE = {{(PRESC_WIDTH-1){1'b0}}, 1'b1};

  logic [PRESC_WIDTH-1:0] presc_cnt;
  logic [PRESC_WIDTH-1:0] presc_nxt;
  logic                   running;
  logic                   tick;
  logic [CARR_WIDTH-1:0]  car_nxt;
  logic [CARR_WIDTH-1:0]  per_nxt;
  logic                   dir_nxt;
  logic                   min_nxt;
  logic                   max_nxt;
  logic                   evt_nxt;

  // Next-state computation: stopped reload, prescaler, and per-mode stepping.
  always_comb begin
    running   = carr_onoff && (carr_mode != 2'd3);
    tick      = running && (presc_cnt == prescaler_in);
    presc_nxt = presc_cnt + P_ONE;
    car_nxt   = carrier_out;
    dir_nxt   = dir_out;
    per_nxt   = period_active;
    min_nxt   = 1'b0;
    max_nxt   = 1'b0;

    if (!running) begin
      // Held: park at the start value and let the shadow follow software.
      presc_nxt = '0;
      car_nxt   = (init_in < period_in) ? init_in : period_in;
      per_nxt   = period_in;
      dir_nxt   = (carr_mode != MODE_DOWN);
    end else if (tick) begin
      presc_nxt = '0;
      case (carr_mode)
        MODE_UP: begin
          dir_nxt = 1'b1;
          car_nxt = (carrier_out >= period_active) ? '0 : carrier_out + C_ONE;
        end
        MODE_DOWN: begin
          dir_nxt = 1'b0;
          if (carrier_out == '0) begin
            // Wrap to the freshly requested top; this is the down-mode load point.
            car_nxt = period_in;
            per_nxt = period_in;
          end else begin
            car_nxt = carrier_out - C_ONE;
          end
        end
        default: begin
          // Up-down: reverse on the tick that lands on an endpoint.
          if (period_active == '0) begin
            car_nxt = '0;
            dir_nxt = ~dir_out;
          end else if (dir_out && (carrier_out < period_active)) begin
            car_nxt = carrier_out + C_ONE;
            dir_nxt = (car_nxt < period_active);
          end else if (dir_out) begin
            car_nxt = carrier_out - C_ONE;
            dir_nxt = (car_nxt == '0);
          end else if (carrier_out == '0) begin
            car_nxt = C_ONE;
            dir_nxt = (C_ONE < period_active);
          end else begin
            car_nxt = carrier_out - C_ONE;
            dir_nxt = (car_nxt == '0);
          end
        end
      endcase

      if ((car_nxt == '0) && (carr_mode != MODE_DOWN)) begin
        per_nxt = period_in;
      end
      min_nxt = (car_nxt == '0);
      max_nxt = (car_nxt == per_nxt);
    end

    case (count_mode)
      CNT_MIN:    evt_nxt = min_nxt;
      CNT_MAX:    evt_nxt = max_nxt;
      CNT_MINMAX: evt_nxt = min_nxt | max_nxt;
      default:    evt_nxt = 1'b0;
    endcase
  end

  // State and output registers; asynchronous reset returns everything to idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_cnt     <= '0;
      carrier_out   <= '0;
      dir_out       <= 1'b1;
      period_active <= '0;
      min_evt       <= 1'b0;
      max_evt       <= 1'b0;
      carr_event    <= 1'b0;
    end else begin
      presc_cnt     <= presc_nxt;
      carrier_out   <= car_nxt;
      dir_out       <= dir_nxt;
      period_active <= per_nxt;
      min_evt       <= min_nxt;
      max_evt       <= max_nxt;
      carr_event    <= evt_nxt;
    end
  end

  // Unused-in-logic constant kept for readability of the mode map.
  logic unused_mode_const;
  assign unused_mode_const = ^MODE_UPDOWN;

endmodule
